// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller between ID and EX.
// A shift-register scoreboard of in-flight writers drives multi-distance forward selects.
module fwd_hazard_ctrl #(
    parameter int unsigned DEPTH    = 3,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned RA_W     = 5,
    parameter int unsigned FWD_W    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [RA_W-1:0]  id_rs1,
    input  logic [RA_W-1:0]  id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [RA_W-1:0]  id_rd,
    input  logic             id_wen,
    input  logic             id_is_load,
    input  logic             adv,
    input  logic             flush,
    output logic             id_stall,
    output logic             id_issue,
    output logic             ex_valid,
    output logic [FWD_W-1:0] ex_fwd_a,
    output logic [FWD_W-1:0] ex_fwd_b
);

    // The WB slot retires on the same edge the register file is read, so it is never
    // searched and is not stored; slots 0..DEPTH-2 are kept.
    localparam int unsigned NSLOT = DEPTH - 1;

    logic [NSLOT-1:0] r_valid;
    logic [NSLOT-1:0] r_wen;
    logic [NSLOT-1:0] r_load;
    logic [RA_W-1:0]  r_rd [NSLOT];
    logic [FWD_W-1:0] r_fwd_a;
    logic [FWD_W-1:0] r_fwd_b;

    logic [NSLOT-1:0] w_prod;
    logic [FWD_W-1:0] w_dist_a;
    logic [FWD_W-1:0] w_dist_b;
    logic             w_haz_a;
    logic             w_haz_b;
    logic             w_hazard;

    always_comb begin
        for (int k = 0; k < int'(NSLOT); k++) begin
            w_prod[k] = r_valid[k] & r_wen[k] & (r_rd[k] != '0);
        end
    end

    // Scan oldest to youngest so the lowest-index match is the one left standing.
    always_comb begin
        w_dist_a = '0;
        w_dist_b = '0;
        w_haz_a  = 1'b0;
        w_haz_b  = 1'b0;
        for (int k = int'(NSLOT) - 1; k >= 0; k--) begin
            if (id_use_rs1 && w_prod[k] && (r_rd[k] == id_rs1)) begin
                w_dist_a = FWD_W'(k + 1);
                w_haz_a  = r_load[k] && ((k + 1) <= int'(LOAD_LAT));
            end
            if (id_use_rs2 && w_prod[k] && (r_rd[k] == id_rs2)) begin
                w_dist_b = FWD_W'(k + 1);
                w_haz_b  = r_load[k] && ((k + 1) <= int'(LOAD_LAT));
            end
        end
    end

    assign w_hazard = w_haz_a | w_haz_b;
    assign id_stall = id_valid & ((~flush & w_hazard) | ~adv);
    assign id_issue = id_valid & adv & ~flush & ~w_hazard;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            r_wen   <= '0;
            r_load  <= '0;
            for (int k = 0; k < int'(NSLOT); k++) begin
                r_rd[k] <= '0;
            end
            r_fwd_a <= '0;
            r_fwd_b <= '0;
        end else if (adv) begin
            for (int k = int'(NSLOT) - 1; k > 0; k--) begin
                r_valid[k] <= r_valid[k-1];
                r_wen[k]   <= r_wen[k-1];
                r_load[k]  <= r_load[k-1];
                r_rd[k]    <= r_rd[k-1];
            end
            r_valid[0] <= id_issue;
            r_wen[0]   <= id_issue & id_wen;
            r_load[0]  <= id_issue & id_is_load;
            r_rd[0]    <= id_rd;
            r_fwd_a    <= id_issue ? w_dist_a : '0;
            r_fwd_b    <= id_issue ? w_dist_b : '0;
        end
    end

    assign ex_valid = r_valid[0];
    assign ex_fwd_a = r_fwd_a;
    assign ex_fwd_b = r_fwd_b;

endmodule

// File: doc/fwd_hazard_ctrl.md
# fwd_hazard_ctrl

Parametrised forwarding and hazard controller for the RISC-V pipeline, sitting between decode (ID) and execute (EX). It tracks every in-flight register-writing instruction in a `DEPTH`-slot scoreboard shift register. From that scoreboard it computes multi-distance forwarding selects for both source operands, stalls ID on load-use hazards with a configurable load latency, and inserts bubbles on flush and stall. It generalises the single-distance writeback-to-EX forwarding of the current control path to any forwarding depth.

## Interface
Parameters:
- `DEPTH`, 3: pipeline slots from EX to retirement (slot 0 = EX, slot `DEPTH-1` = WB); legal range 2..8.
- `LOAD_LAT`, 1: extra slots a load result is unavailable after EX; legal range 0..`DEPTH-2`.
- `RA_W`, 5: register address width.
- `FWD_W`, `$clog2(DEPTH)`: width of the forward select outputs.

Ports:
- `clk`: input, 1 bit. Single clock.
- `reset`: input, 1 bit. Synchronous, active-high.
- `id_valid`: input, 1 bit. ID holds a valid instruction.
- `id_rs1`, `id_rs2`: input, `RA_W` bits. Source register addresses.
- `id_use_rs1`, `id_use_rs2`: input, 1 bit each. The instruction actually reads that source.
- `id_rd`: input, `RA_W` bits. Destination register.
- `id_wen`: input, 1 bit. The instruction writes `id_rd`.
- `id_is_load`: input, 1 bit. The instruction is a load.
- `adv`: input, 1 bit. The pipeline may advance this cycle; 0 freezes everything (e.g. dcache miss).
- `flush`: input, 1 bit. Taken branch/jump resolved in EX; kills the ID instruction.
- `id_stall`: output, 1 bit. Combinational; hold IF/ID this cycle.
- `id_issue`: output, 1 bit. Combinational; the ID instruction moves to EX at this edge.
- `ex_valid`: output, 1 bit. Registered; slot 0 holds a real instruction.
- `ex_fwd_a`, `ex_fwd_b`: output, `FWD_W` bits. Registered; 0 = register file, d = forward result of the producer d slots ahead of EX (1..`DEPTH-1`).

## Operation
- Each slot holds {valid, wen, rd, is_load}. An entry is a producer only if valid, wen=1 and rd≠0.
- Hazard search for a used source rs runs over slots 0..`DEPTH-2`. The youngest (lowest index) matching producer wins. Slot `DEPTH-1` is ignored, because it retires this edge and the register file is read at EX entry.
- Match at slot k gives candidate distance d = k+1.
- Load hazard: the winning match is a load and d ≤ `LOAD_LAT`. Such a source forces `id_stall`.
- `id_stall` = id_valid & ~flush & (hazard on rs1 | hazard on rs2), or id_valid & ~adv.
- `id_issue` = id_valid & adv & ~flush & ~hazard.
- On an edge with adv=1:
  - Slots shift by one; slot `DEPTH-1` is discarded.
  - Slot 0 loads the ID instruction if `id_issue`, otherwise a bubble (valid=0).
  - `ex_fwd_a`/`ex_fwd_b` load d for a winning match, 0 if there is no match or the source is unused, and 0 on a bubble.
- On an edge with adv=0, all state and registered outputs hold.
- Flush has priority over hazard. The ID instruction becomes a bubble, `id_stall`=0, and slots already in flight are unaffected.
- rd=0 never matches. A source with use=0 never matches or stalls.
- Both sources may match different slots independently. Stall is asserted if either source hazards.

## Timing
- Reset: all slots invalid, `ex_valid`=0, `ex_fwd_a`=`ex_fwd_b`=0. After reset `id_stall`=0 unless adv=0.
- A reset asserted mid-operation clears the scoreboard on that edge. The in-flight instructions are dropped.
- Forward-select latency: decided in ID, registered, and valid during the cycle the consumer is in EX.
- Load-use penalty: exactly `LOAD_LAT`+1−d stall cycles for a dependent instruction at distance d. With defaults, a back-to-back load→use costs 1 bubble, then forwards from d=2.
- A stalled instruction re-evaluates every cycle. No issue happens while adv=0.

## Test plan
- Back-to-back ALU dependency: `add x5` then `sub` using x5 as rs1. Required: no stall, and `ex_fwd_a`=1 when the sub is in EX.
- Load-use, defaults: `lw x6` then `add` using rs2=x6. Required: `id_stall`=1 for one cycle, `ex_valid`=0 bubble, then `ex_fwd_b`=2.
- Youngest wins: writes to x7 at distances 2 and 1, then a reader of x7. Required: `ex_fwd_a`=1. With rd=x0 instead, `ex_fwd_a`=0.
- Flush over stall: load-use pair with flush=1 in the use cycle. Required: `id_stall`=0, `id_issue`=0, bubble into EX, scoreboard otherwise unchanged.
- Freeze: adv=0 for 3 cycles mid-stream. Required: `ex_valid` and `ex_fwd_*` hold, `id_issue`=0; forwarding distances are unchanged after release.
- `DEPTH`=5, `LOAD_LAT`=2 with load then use at d=1,2,3. Required: 2, 1 and 0 stall cycles respectively; final `ex_fwd`=3.
